// File: rtl/operand_fetch_pkg.sv
// Shared constants and types for the operand fetch stage.
//   REG_IDX_W : register index width
//   DATA_W    : operand data width (signed)
//   OP_W      : opcode tag width
//   NUM_REGS  : number of architectural registers (all general purpose)
package operand_fetch_pkg;

    localparam int REG_IDX_W = 3;
    localparam int DATA_W    = 8;
    localparam int OP_W      = 4;
    localparam int NUM_REGS  = 8;

    typedef logic [REG_IDX_W-1:0]     reg_idx_t;
    typedef logic signed [DATA_W-1:0] data_t;
    typedef logic [OP_W-1:0]          op_t;

endpackage

// File: rtl/operand_fetch_bypass.sv
// Per-operand write-back bypass mux.
// Ports:
//   i_src_idx  : source register index of this operand
//   i_base     : value used when the write port is not targeting i_src_idx
//   i_wb_valid : write port enable
//   i_wb_rd    : write port register index
//   i_wb_data  : write port data
//   o_data     : selected operand value
module operand_bypass
    import operand_fetch_pkg::*;
(
    input  logic     i_src_idx_valid_unused_never,
    input  reg_idx_t i_src_idx,
    input  data_t    i_base,
    input  logic     i_wb_valid,
    input  reg_idx_t i_wb_rd,
    input  data_t    i_wb_data,
    output data_t    o_data
);

    logic w_hit;

    assign w_hit  = i_wb_valid && (i_wb_rd == i_src_idx) && !i_src_idx_valid_unused_never;
    assign o_data = w_hit ? i_wb_data : i_base;

endmodule

// File: rtl/operand_fetch.sv
// Two-stage operand fetch: S1 holds the instruction while the registered
// register file returns data, S2 is the output register toward execute.
// Ports:
//   clk, reset_n                  : clock, async active-low reset
//   in_valid/in_ready             : decode-side handshake
//   in_rs1, in_rs2, in_rd, in_op  : incoming instruction fields
//   rf_read_reg1/2                : register file read addresses
//   rf_read_data1/2               : register file data (one cycle after address)
//   wb_valid, wb_rd, wb_data      : copy of register file write port (bypass)
//   out_valid/out_ready           : execute-side handshake
//   out_a, out_b, out_rd, out_op  : fetched operands and passthrough fields
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic     clk,
    input  logic     reset_n,
    input  logic     in_valid,
    output logic     in_ready,
    input  reg_idx_t in_rs1,
    input  reg_idx_t in_rs2,
    input  reg_idx_t in_rd,
    input  op_t      in_op,
    output reg_idx_t rf_read_reg1,
    output reg_idx_t rf_read_reg2,
    input  data_t    rf_read_data1,
    input  data_t    rf_read_data2,
    input  logic     wb_valid,
    input  reg_idx_t wb_rd,
    input  data_t    wb_data,
    output logic     out_valid,
    input  logic     out_ready,
    output data_t    out_a,
    output data_t    out_b,
    output reg_idx_t out_rd,
    output op_t      out_op
);

    logic     r_s1_valid;
    reg_idx_t r_s1_rs1, r_s1_rs2, r_s1_rd;
    op_t      r_s1_op;

    logic     r_out_valid;
    data_t    r_out_a, r_out_b;
    reg_idx_t r_out_rd, r_out_rs1, r_out_rs2;
    op_t      r_out_op;

    logic     w_advance2, w_accept, w_load2, w_hold2, w_sel_in;
    reg_idx_t w_idx_a, w_idx_b;
    data_t    w_base_a, w_base_b, w_byp_a, w_byp_b;

    assign w_advance2 = !r_out_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_advance2;
    assign w_accept   = in_valid && in_ready;
    assign w_load2    = r_s1_valid && w_advance2;
    assign w_hold2    = r_out_valid && !out_ready;

    // With S1 empty the held indices are meaningless, so present the incoming
    // indices; this keeps the read port tracking decode through and after reset.
    assign w_sel_in     = in_ready && (in_valid || !r_s1_valid);
    assign rf_read_reg1 = w_sel_in ? in_rs1 : r_s1_rs1;
    assign rf_read_reg2 = w_sel_in ? in_rs2 : r_s1_rs2;

    // One mux per operand serves both the S1->S2 capture and the stalled-S2
    // refresh; the two cases are mutually exclusive.
    assign w_idx_a  = w_load2 ? r_s1_rs1      : r_out_rs1;
    assign w_idx_b  = w_load2 ? r_s1_rs2      : r_out_rs2;
    assign w_base_a = w_load2 ? rf_read_data1 : r_out_a;
    assign w_base_b = w_load2 ? rf_read_data2 : r_out_b;

    operand_bypass u_byp_a (
        .i_src_idx_valid_unused_never (1'b0),
        .i_src_idx  (w_idx_a),
        .i_base     (w_base_a),
        .i_wb_valid (wb_valid),
        .i_wb_rd    (wb_rd),
        .i_wb_data  (wb_data),
        .o_data     (w_byp_a)
    );

    operand_bypass u_byp_b (
        .i_src_idx_valid_unused_never (1'b0),
        .i_src_idx  (w_idx_b),
        .i_base     (w_base_b),
        .i_wb_valid (wb_valid),
        .i_wb_rd    (wb_rd),
        .i_wb_data  (wb_data),
        .o_data     (w_byp_b)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_rs1    <= '0;
            r_s1_rs2    <= '0;
            r_s1_rd     <= '0;
            r_s1_op     <= '0;
            r_out_valid <= 1'b0;
            r_out_a     <= '0;
            r_out_b     <= '0;
            r_out_rd    <= '0;
            r_out_op    <= '0;
            r_out_rs1   <= '0;
            r_out_rs2   <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid <= 1'b1;
                r_s1_rs1   <= in_rs1;
                r_s1_rs2   <= in_rs2;
                r_s1_rd    <= in_rd;
                r_s1_op    <= in_op;
            end else if (w_advance2) begin
                r_s1_valid <= 1'b0;
            end

            if (w_load2) begin
                r_out_valid <= 1'b1;
                r_out_a     <= w_byp_a;
                r_out_b     <= w_byp_b;
                r_out_rd    <= r_s1_rd;
                r_out_op    <= r_s1_op;
                r_out_rs1   <= r_s1_rs1;
                r_out_rs2   <= r_s1_rs2;
            end else if (w_hold2) begin
                r_out_a <= w_byp_a;
                r_out_b <= w_byp_b;
            end else if (w_advance2) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_a     = r_out_a;
    assign out_b     = r_out_b;
    assign out_rd    = r_out_rd;
    assign out_op    = r_out_op;

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have: reset_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: in_valid  in  1 / in_ready  out  1  decode-side handshake; transfer when both high.
REQ-004 SHALL have: in_rs1, in_rs2, in_rd  in  3 each  source/destination register indices; in_op  in  4  opcode tag.
REQ-005 SHALL have: rf_read_reg1, rf_read_reg2  out  3 each  register file read addresses.
REQ-006 SHALL have: rf_read_data1, rf_read_data2  in  8 signed  register file data; the file registers addresses, so data is valid one cycle after the address is presented.
REQ-007 SHALL have: wb_valid  in  1, wb_rd  in  3, wb_data  in  8 signed  copy of the register file write port (RegWrite, write_reg, write_data), used for bypass.
REQ-008 SHALL have: out_valid  out  1 / out_ready  in  1  execute-side handshake; out_a, out_b  out  8 signed; out_rd  out  3; out_op  out  4.

Function
REQ-009 SHALL be a 2-stage pipeline: S1 (address issued, data pending) and S2 (output register); accept on cycle N -> out_valid at N+2; sustained throughput 1 per cycle.
REQ-010 SHALL define advance2 = !out_valid || out_ready, and in_ready = !s1_valid || advance2.
REQ-011 SHALL drive rf_read_regX = in_rsX when in_valid && in_ready, else the held S1 indices s1_rsX.
REQ-012 SHALL, on acceptance, load s1_valid=1, s1_rs1, s1_rs2, s1_rd, s1_op; otherwise clear s1_valid when S1 advances.
REQ-013 SHALL, when s1_valid && advance2, load S2 with out_a = (wb_valid && wb_rd==s1_rs1) ? wb_data : rf_read_data1; out_b likewise from s1_rs2.
REQ-014 SHALL, while S1 is blocked (s1_valid && !advance2), keep rf_read_regX on s1_rsX so read data stays current.
REQ-015 SHALL, while out_valid && !out_ready, hold out_rd/out_op stable and overwrite out_a (out_b) with wb_data whenever wb_valid && wb_rd equals the stored source index of that operand.
REQ-016 SHALL bypass both operands when rs1==rs2==wb_rd.
REQ-017 SHALL clear out_valid on out_ready when S1 is empty; shall never drop or duplicate an accepted instruction.
REQ-018 SHALL treat all 8 registers uniformly (no hardwired zero); arithmetic unsigned-free, data passed unmodified 8-bit signed.

Reset
REQ-019 SHALL, while reset_n=0, asynchronously force s1_valid=0, out_valid=0, out_a=out_b=0, out_rd=0, out_op=0, stored indices=0.
REQ-020 SHALL drive in_ready=1 and rf_read_regX=in_rsX during and immediately after reset.
REQ-021 SHALL discard any in-flight instruction on reset mid-operation; first post-reset acceptance completes normally at N+2.

Structure
REQ-022 SHALL place shared constants in a package: REG_IDX_W=3, DATA_W=8, OP_W=4, NUM_REGS=8.
REQ-023 SHALL implement the per-operand bypass mux as one sub-module, operand_bypass, instantiated twice in S1->S2 and reused for REQ-015 hold update.
REQ-024 SHALL contain no combinational path from out_ready to rf_read_regX other than via in_ready.

Verification
REQ-025 SHALL check: R3=0x12, R5=-4 in file; accept rs1=3, rs2=5, op=2 at cycle 0, out_ready=1 -> cycle 2 out_valid=1, out_a=0x12, out_b=0xFC, out_op=2.
REQ-026 SHALL check: accept rs1=2 at cycle 0; cycle 1 wb_valid=1, wb_rd=2, wb_data=0x7F -> out_a=0x7F.
REQ-027 SHALL check: out_ready=0 for 4 cycles with S2 and S1 full -> in_ready=0, outputs stable; wb write to out's rs1 during stall -> out_a updates; release -> both emitted in order.
REQ-028 SHALL check: back-to-back 8 instructions, out_ready=1 -> 8 outputs on consecutive cycles, correct operands, no gaps.
REQ-029 SHALL check: reset_n asserted with S1 and S2 full -> out_valid=0 immediately (asynchronous), no output emitted after release until new acceptance.
REQ-030 SHALL check: rs1=rs2=6 with wb_rd=6, wb_data=-128 in capture cycle -> out_a=out_b=0x80.
